// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Divide ops have the top opcode bit set; signed ops have the low bit set.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core. Produces the HI/LO pair for one MD op,
// including the divide-by-zero and signed-overflow results.
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       md_op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic               sgn;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, b_div;
   logic [WIDTH-1:0]   q_mag, r_mag, quo, rem;

   // Full-width product and sign-magnitude division, then select by opcode
   always_comb begin
      sgn    = op_is_signed(md_op);
      a_ext  = sgn ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
      b_ext  = sgn ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
      prod   = a_ext * b_ext;

      a_neg  = sgn & rs_val[WIDTH-1];
      b_neg  = sgn & rt_val[WIDTH-1];
      a_mag  = a_neg ? -rs_val : rs_val;
      b_mag  = b_neg ? -rt_val : rt_val;
      // Substitute 1 for a zero divisor so the divider never sees zero;
      // the zero case is overridden below.
      b_div  = (b_mag == '0) ? WIDTH'(1) : b_mag;
      q_mag  = a_mag / b_div;
      r_mag  = a_mag % b_div;
      quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem    = a_neg ? -r_mag : r_mag;

      res_hi = '0;
      res_lo = '0;
      if (!op_is_div(md_op)) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (rt_val == '0) begin
         res_hi = rs_val;
         res_lo = '1;
      end else if (md_op == MD_DIV && rs_val == MIN_VAL && rt_val == '1) begin
         res_hi = '0;
         res_lo = MIN_VAL;
      end else begin
         res_hi = rem;
         res_lo = quo;
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch and held in pending registers until the
// configured latency expires, then committed to HI/LO with a done pulse.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate into {HI,LO}).
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       md_op,
   input  logic             madd,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hilo_we,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             launch, commit, abort;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic [WIDTH-1:0] pend_hi, pend_lo;

`ifdef MDU_MADD_EN
   logic             pend_madd;
`else
   logic             unused_madd;
   assign unused_madd = madd;
`endif

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .md_op  (md_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: launch from IDLE unless flushed, leave RUN on last count or flush
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && !flush) state_nxt = S_RUN;
         S_RUN:   if (flush || count == CNT_W'(1)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: busy level plus launch/commit/abort strobes for the datapath
   always_comb begin
      busy   = (state == S_RUN);
      launch = (state == S_IDLE) && start && !flush;
      abort  = (state == S_RUN) && flush;
      commit = (state == S_RUN) && !flush && (count == CNT_W'(1));
   end

   // Latency counter and pending result staging
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
`ifdef MDU_MADD_EN
         pend_madd <= 1'b0;
`endif
      end else if (launch) begin
         count     <= op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         pend_hi   <= res_hi;
         pend_lo   <= res_lo;
`ifdef MDU_MADD_EN
         pend_madd <= madd && !op_is_div(md_op);
`endif
      end else if (commit || abort) begin
         count     <= '0;
      end else if (busy) begin
         count     <= count - CNT_W'(1);
      end
   end

   // HI/LO: MD commit has priority; mthi/mtlo only take effect while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
`ifdef MDU_MADD_EN
         // The accumulate addend is the HI/LO value at commit time.
         if (pend_madd) {hi, lo} <= {hi, lo} + {pend_hi, pend_lo};
         else           {hi, lo} <= {pend_hi, pend_lo};
`else
         {hi, lo} <= {pend_hi, pend_lo};
`endif
      end else if (hilo_we && state == S_IDLE) begin
         if (hilo_sel) lo <= wdata;
         else          hi <= wdata;
      end
   end

   // One-cycle done pulse following the commit edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) done <= 1'b0;
      else          done <= commit;
   end

endmodule
